// File: rtl/mult_controller_if.sv
// mult_controller_if -- handshake and datapath-control bundle for the
// shift-and-add multiplier controller.
//   start       requester -> controller, multiply request
//   x_flag      datapath  -> controller, X register nonzero
//   x_odd_flag  datapath  -> controller, X register LSB
//   x_sel/y_sel controller -> datapath, mux selects (0 = operand, 1 = shifted)
//   x_ld/y_ld   controller -> datapath, register load enables
//   add_en      controller -> datapath, acc <= acc + Y
//   out_en      controller -> datapath, mult <= acc
//   dp_rst      controller -> datapath, synchronous active-low clear
//   busy/done/err controller -> requester, status
// master = controller side, slave = datapath/requester side.
interface mult_controller_if;
   logic start;
   logic x_flag;
   logic x_odd_flag;
   logic x_sel;
   logic y_sel;
   logic x_ld;
   logic y_ld;
   logic add_en;
   logic out_en;
   logic dp_rst;
   logic busy;
   logic done;
   logic err;

   modport master (
      input  start, x_flag, x_odd_flag,
      output x_sel, y_sel, x_ld, y_ld, add_en, out_en, dp_rst, busy, done, err
   );

   modport slave (
      output start, x_flag, x_odd_flag,
      input  x_sel, y_sel, x_ld, y_ld, add_en, out_en, dp_rst, busy, done, err
   );
endinterface

// File: rtl/mult_controller.sv
// mult_controller -- Moore FSM sequencing a shift-and-add multiplier datapath.
// Ports:
//   clk  single clock, rising edge
//   rst  synchronous active-low reset
//   bus  mult_controller_if.master (start/flags in, datapath controls and
//        busy/done/err out)
// Parameter MAX_ITER bounds the number of SHIFT iterations; hitting it
// aborts the run through FAULT (done with err=1, mult left at 0).
module mult_controller #(
   parameter int MAX_ITER = 17
) (
   input logic               clk,
   input logic               rst,
   mult_controller_if.master bus
);

   localparam int CW = $clog2(MAX_ITER + 1);
   localparam logic [CW-1:0] LAST = CW'(MAX_ITER - 1);

   typedef enum logic [3:0] {
      IDLE, CLEAR, LOAD, TEST, ACC, SHIFT, OUT, DONE, FAULT
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt;

   logic x_sel, y_sel, x_ld, y_ld, add_en, out_en, dp_rst_st;
   logic busy, done, err;

   // state register
   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // iteration counter: cleared in LOAD, bumped once per SHIFT
   always_ff @(posedge clk) begin
      if (!rst)                cnt <= '0;
      else if (state == LOAD)  cnt <= '0;
      else if (state == SHIFT) cnt <= cnt + CW'(1);
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = CLEAR;
         CLEAR:   state_nxt = LOAD;
         LOAD:    state_nxt = TEST;
         TEST: begin
            if (!bus.x_flag)        state_nxt = OUT;
            else if (bus.x_odd_flag) state_nxt = ACC;
            else                     state_nxt = SHIFT;
         end
         ACC:     state_nxt = SHIFT;
         // cnt still holds the pre-increment value here, so compare to LAST
         SHIFT:   state_nxt = (cnt == LAST) ? FAULT : TEST;
         OUT:     state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         FAULT:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // output decode, state only
   always_comb begin
      x_sel     = 1'b0;
      y_sel     = 1'b0;
      x_ld      = 1'b0;
      y_ld      = 1'b0;
      add_en    = 1'b0;
      out_en    = 1'b0;
      dp_rst_st = 1'b1;
      done      = 1'b0;
      err       = 1'b0;
      busy      = (state != IDLE);
      case (state)
         CLEAR: dp_rst_st = 1'b0;
         LOAD: begin
            x_ld = 1'b1;
            y_ld = 1'b1;
         end
         ACC:   add_en = 1'b1;
         SHIFT: begin
            x_sel = 1'b1;
            y_sel = 1'b1;
            x_ld  = 1'b1;
            y_ld  = 1'b1;
         end
         OUT:   out_en = 1'b1;
         DONE:  done = 1'b1;
         FAULT: begin
            done = 1'b1;
            err  = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.x_sel  = x_sel;
   assign bus.y_sel  = y_sel;
   assign bus.x_ld   = x_ld;
   assign bus.y_ld   = y_ld;
   assign bus.add_en = add_en;
   assign bus.out_en = out_en;
   // rst passes straight through so the datapath clears on the same edge
   assign bus.dp_rst = rst & dp_rst_st;
   assign bus.busy   = busy;
   assign bus.done   = done;
   assign bus.err    = err;

endmodule
